// File: rtl/shift_counter_param.sv
// Parametrised Johnson / ring shift counter with runtime mode select,
// up/down stepping, clock enable, synchronous load, illegal-state recovery,
// binary index decode and registered wrap / error pulses.
module shift_counter_param #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             tc,
    output logic             err
);

    typedef enum logic {
        MODE_JOHNSON = 1'b0,
        MODE_RING    = 1'b1
    } mode_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    logic [IW-1:0]    idx_c;
    logic [IW-1:0]    last_idx;
    logic             cur_legal;

    // Johnson codes have at most one boundary between adjacent bits
    function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-2:0] edges;
        edges = v[WIDTH-2:0] ^ v[WIDTH-1:1];
        return $countones(edges) <= 1;
    endfunction

    function automatic logic is_legal(input logic [WIDTH-1:0] v, input mode_e m);
        if (m == MODE_RING) return $countones(v) == 1;
        return johnson_legal(v);
    endfunction

    function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
        if (m == MODE_RING) return WIDTH'(1);
        return '0;
    endfunction

    // Decode the current state into its sequence position (0 when illegal)
    always_comb begin
        int unsigned ones;
        idx_c     = '0;
        cur_legal = is_legal(cnt_q, mode_q);
        ones      = $countones(cnt_q);
        if (cur_legal) begin
            if (mode_q == MODE_JOHNSON) begin
                if (!cnt_q[WIDTH-1]) idx_c = IW'(ones);
                else                 idx_c = IW'(2 * WIDTH - ones);
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q[i]) idx_c = IW'(i);
                end
            end
        end
        last_idx = (mode_q == MODE_RING) ? IW'(WIDTH - 1) : IW'(2 * WIDTH - 1);
    end

    // Per-edge action: mode switch > load > illegal recovery > step > hold
    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        tc_d   = 1'b0;
        err_d  = 1'b0;
        if (mode_e'(mode) != mode_q) begin
            mode_d = mode_e'(mode);
            cnt_d  = seed_of(mode_e'(mode));
        end else if (load) begin
            if (is_legal(load_val, mode_q)) begin
                cnt_d = load_val;
            end else begin
                cnt_d = seed_of(mode_q);
                err_d = 1'b1;
            end
        end else if (!cur_legal) begin
            cnt_d = seed_of(mode_q);
            err_d = 1'b1;
        end else if (en) begin
            if (mode_q == MODE_RING) begin
                cnt_d = up ? {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]}
                           : {cnt_q[0], cnt_q[WIDTH-1:1]};
            end else begin
                cnt_d = up ? {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]}
                           : {~cnt_q[0], cnt_q[WIDTH-1:1]};
            end
            tc_d = up ? (idx_c == last_idx) : (idx_c == '0);
        end
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= MODE_JOHNSON;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
        end
    end

    assign q   = cnt_q;
    assign idx = idx_c;
    assign tc  = tc_q;
    assign err = err_q;

endmodule

// File: tb/tb_shift_counter_param.sv
// Directed self-checking bench for shift_counter_param at WIDTH = 4.
module tb_shift_counter_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [2:0] idx;
    logic       tc;
    logic       err;

    int n_cmp;
    int n_bad;

    typedef struct {
        string      name;
        logic       en;
        logic       up;
        logic       mode;
        logic       load;
        logic [3:0] lv;
        logic [3:0] eq;
        logic [2:0] eidx;
        logic       etc;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    shift_counter_param #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .idx      (idx),
        .tc       (tc),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string nm, input logic e, input logic u, input logic m,
                       input logic l, input logic [3:0] lv, input logic [3:0] eq,
                       input logic [2:0] ei, input logic et, input logic ee);
        vec_t v;
        v.name = nm; v.en = e; v.up = u; v.mode = m; v.load = l; v.lv = lv;
        v.eq = eq; v.eidx = ei; v.etc = et; v.eerr = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] eq, input logic [2:0] ei,
                       input logic et, input logic ee);
        n_cmp++;
        if (q !== eq) begin
            n_bad++;
            $display("FAIL %s q: got %b expected %b", nm, q, eq);
        end
        n_cmp++;
        if (idx !== ei) begin
            n_bad++;
            $display("FAIL %s idx: got %0d expected %0d", nm, idx, ei);
        end
        n_cmp++;
        if (tc !== et) begin
            n_bad++;
            $display("FAIL %s tc: got %b expected %b", nm, tc, et);
        end
        n_cmp++;
        if (err !== ee) begin
            n_bad++;
            $display("FAIL %s err: got %b expected %b", nm, err, ee);
        end
    endtask

    task automatic drive(input logic e, input logic u, input logic m,
                         input logic l, input logic [3:0] lv);
        en = e; up = u; mode = m; load = l; load_val = lv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 4'b0000);

        //   name        en up md ld lv       q        idx  tc err
        add("j_f1",      1, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
        add("j_f2",      1, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
        add("j_f3",      1, 1, 0, 0, 4'b0000, 4'b0111, 3'd3, 0, 0);
        add("j_f4",      1, 1, 0, 0, 4'b0000, 4'b1111, 3'd4, 0, 0);
        add("j_f5",      1, 1, 0, 0, 4'b0000, 4'b1110, 3'd5, 0, 0);
        add("j_f6",      1, 1, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0);
        add("j_f7",      1, 1, 0, 0, 4'b0000, 4'b1000, 3'd7, 0, 0);
        add("j_wrap",    1, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 0);
        add("j_f9",      1, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0);
        add("j_f10",     1, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0);
        add("j_f11",     1, 1, 0, 0, 4'b0000, 4'b0111, 3'd3, 0, 0);
        add("to_ring",   1, 1, 1, 0, 4'b0000, 4'b0001, 3'd0, 0, 0);
        add("r_f1",      1, 1, 1, 0, 4'b0000, 4'b0010, 3'd1, 0, 0);
        add("r_f2",      1, 1, 1, 0, 4'b0000, 4'b0100, 3'd2, 0, 0);
        add("r_f3",      1, 1, 1, 0, 4'b0000, 4'b1000, 3'd3, 0, 0);
        add("r_wrap",    1, 1, 1, 0, 4'b0000, 4'b0001, 3'd0, 1, 0);
        add("r_revwrap", 1, 0, 1, 0, 4'b0000, 4'b1000, 3'd3, 1, 0);
        add("r_rev",     1, 0, 1, 0, 4'b0000, 4'b0100, 3'd2, 0, 0);
        add("r_badload", 0, 0, 1, 1, 4'b0110, 4'b0001, 3'd0, 0, 1);
        add("r_hold",    0, 0, 1, 0, 4'b0000, 4'b0001, 3'd0, 0, 0);
        add("r_load",    0, 0, 1, 1, 4'b0100, 4'b0100, 3'd2, 0, 0);
        add("mode_ld",   0, 0, 0, 1, 4'b1100, 4'b0000, 3'd0, 0, 0);
        add("ld_vs_en",  1, 1, 0, 1, 4'b1100, 4'b1100, 3'd6, 0, 0);
        add("j_badload", 0, 0, 0, 1, 4'b0101, 4'b0000, 3'd0, 0, 1);
        add("j_hold",    0, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 0, 0);
        add("j_revwrap", 1, 0, 0, 0, 4'b0000, 4'b1000, 3'd7, 1, 0);
        add("j_rev",     1, 0, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0);
        add("j_hold2",   0, 0, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0);

        #12;
        chk("reset", 4'b0000, 3'd0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].up, vecs[i].mode, vecs[i].load, vecs[i].lv);
            step();
            chk(vecs[i].name, vecs[i].eq, vecs[i].eidx, vecs[i].etc, vecs[i].eerr);
        end

        // Async reset mid-cycle from 1110, then release with en=1
        drive(0, 1, 0, 1, 4'b1110);
        step();
        chk("ld_1110", 4'b1110, 3'd5, 0, 0);
        drive(0, 1, 0, 0, 4'b0000);
        #2 rst_n = 1'b0;
        #1 chk("arst_mid", 4'b0000, 3'd0, 0, 0);
        step();
        chk("arst_held", 4'b0000, 3'd0, 0, 0);
        drive(1, 1, 0, 0, 4'b0000);
        rst_n = 1'b1;
        step();
        chk("rel_en", 4'b0001, 3'd1, 0, 0);

        // Async reset clears a pending err pulse; release with mode=1
        drive(0, 1, 0, 1, 4'b0101);
        step();
        chk("err_set", 4'b0000, 3'd0, 0, 1);
        drive(1, 1, 1, 0, 4'b0000);
        #2 rst_n = 1'b0;
        #1 chk("arst_err", 4'b0000, 3'd0, 0, 0);
        rst_n = 1'b1;
        step();
        chk("rel_mode1", 4'b0001, 3'd0, 0, 0);
        step();
        chk("rel_step", 4'b0010, 3'd1, 0, 0);
        drive(0, 1, 1, 0, 4'b0000);
        step();
        chk("rel_hold", 4'b0010, 3'd1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_counter_param.md
# shift_counter_param

Parametrised twisted-ring/ring shift counter with a runtime-selectable mode. Supports up/down stepping, clock enable and synchronous parallel load. Illegal states are detected and self-corrected. Outputs a binary state index and a wrap pulse. Used as a glitch-free sequencer and phase generator wherever decoded one-hot or Johnson phases are needed.

## Interface
- WIDTH, 4, number of state bits; legal range ≥ 2
- IW, $clog2(2*WIDTH), width of the index output (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  step enable
- up  input  1  direction: 1 = forward, 0 = reverse
- mode  input  1  0 = Johnson (sequence length 2·WIDTH), 1 = ring/one-hot (sequence length WIDTH)
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value to load
- q  output  WIDTH  counter state (registered)
- idx  output  IW  binary position of q in the current sequence (combinational from q and mode_q)
- tc  output  1  registered one-cycle wrap pulse
- err  output  1  registered one-cycle illegal-state/illegal-load pulse

## Operation
- Internal register mode_q holds the active mode. On reset: q = 0, mode_q = 0 (Johnson), tc = 0, err = 0.
- Seed pattern:
  - Johnson: all zeros.
  - Ring: 0…01.
- Johnson step:
  - Forward: q ← {q[W-2:0], ~q[W-1]}.
  - Reverse: q ← {~q[0], q[W-1:1]}.
- Ring step:
  - Forward: rotate left, q ← {q[W-2:0], q[W-1]}.
  - Reverse: rotate right.
- Legal states:
  - Johnson: at most one i in 0..W-2 with q[i] ≠ q[i+1].
  - Ring: exactly one bit set.
- idx:
  - Johnson: popcount(q) if q[W-1] = 0, else 2W − popcount(q); e.g. W=4: 1111→4, 1110→5.
  - Ring: position of the set bit.
  - Illegal state: idx = 0.
- Per-edge priority, highest first. Exactly one action occurs per edge.
  1. mode ≠ mode_q: mode_q ← mode, q ← seed of the new mode, tc = 0, err = 0.
  2. load = 1:
     - load_val legal in mode_q: q ← load_val.
     - load_val illegal: q ← seed, err = 1.
     - tc = 0 in both cases.
  3. q illegal (e.g. upset): q ← seed, err = 1, tc = 0. Occurs regardless of en.
  4. en = 1: step in direction up. tc = 1 iff the step wraps, i.e. idx goes LEN−1→0 (forward) or 0→LEN−1 (reverse).
  5. Otherwise: hold q; tc = 0, err = 0.
- Direction and mode may change on any cycle. Direction takes effect on the same edge it is sampled.

## Timing
- q, tc and err update on the same rising clk edge. tc and err are high for exactly that following cycle.
- idx is valid in the same cycle as q; zero-latency decode.
- Load-to-output latency is 1 cycle. Step latency is 1 cycle per en.
- Mode switch takes 1 cycle. Stepping resumes on the next en edge after the switch.
- Asynchronous reset clears all state immediately, mid-sequence included.
- Reset deassertion is synchronised externally. The first edge after release follows the priority list, so mode=1 at release triggers a mode switch to 0001 first.
- Continuous en with fixed direction:
  - tc period is 2W cycles in Johnson mode, W cycles in ring mode.
  - Reversing direction at idx 0 produces an immediate wrap and tc.

## Test plan
- Johnson, W=4: reset, en=1, up=1 for 9 cycles → q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001. idx = 1..7, 0, 1. tc high only in the cycle q = 0000.
- Reverse wrap, Johnson: from reset, en=1, up=0 → q = 1000 (idx 7) with tc=1. Next edge gives q = 1100 (idx 6).
- Ring switch: mode=1 at q=0111 → next q = 0001, tc=0. Then 4 forward steps → 0010, 0100, 1000, 0001 with tc on 0001. Reverse from 0001 → 1000 with tc.
- Load: Johnson load_val=1100 → q=1100, idx=6. load_val=0101 → q=0000, err=1 for one cycle. In ring mode, load_val=0110 → q=0001, err=1.
- Priority: load=1 and en=1 on the same edge → load wins, no step. A mode change together with load → mode switch wins, q = seed.
- Async reset: assert rst_n=0 mid-cycle at q=1110 → q=0000, tc=err=0 before the next clk edge. Release with en=1 → 0001 on the next edge.
